alu_issue_seq: RTL and testbench

//  Issue-side sequencer for the registered ALU in the multicycle RV32I core. Accepts one decoded
//  OP/OP-IMM instruction word, reads rs1/rs2, drives oprand1/oprand2/alu_op into the ALU and

---
 rtl/alu_issue_seq.sv | 231 +++++++++++++++++++++++
 tb/tb_alu_issue_seq.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_seq.sv
// rtl/alu_issue_seq.sv - issue-side sequencer driving the registered ALU for RV32I OP/OP-IMM
//
// Accepts one decoded OP/OP-IMM instruction, presents operands and op to a
// registered ALU, collects the result and writes rd back to the register file.
//
// Ports:
//   clk, reset                 core clock, synchronous active-high reset
//   instr_valid/instr_ready    instruction handshake; instr holds the RV32I word
//   rs1_addr/rs2_addr          register-file read addresses (combinational from instr)
//   rs1_data/rs2_data          register-file read data, valid with the addresses
//   alu_oprand1/2, alu_op      operands and operation to the ALU
//   alu_result                 ALU result, valid ALU_LAT cycles after presentation
//   rd_we/rd_addr/rd_wdata     register-file write port, rd_we is a 1-cycle pulse
//   done, illegal              retire pulse; illegal marks an unsupported instruction

module alu_issue_seq #(
    parameter int XLEN    = 32,
    parameter int ALU_LAT = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            instr_valid,
    output logic            instr_ready,
    input  logic [31:0]     instr,
    output logic [4:0]      rs1_addr,
    output logic [4:0]      rs2_addr,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic [XLEN-1:0] alu_oprand1,
    output logic [XLEN-1:0] alu_oprand2,
    output logic [3:0]      alu_op,
    input  logic [XLEN-1:0] alu_result,
    output logic            rd_we,
    output logic [4:0]      rd_addr,
    output logic [XLEN-1:0] rd_wdata,
    output logic            done,
    output logic            illegal
);

    // ALU operation codes shared with the ALU
    localparam logic [3:0] ALUOP_NON = 4'd0;
    localparam logic [3:0] ALUOP_ADD = 4'd1;
    localparam logic [3:0] ALUOP_SUB = 4'd2;
    localparam logic [3:0] ALUOP_AND = 4'd3;
    localparam logic [3:0] ALUOP_OR  = 4'd4;
    localparam logic [3:0] ALUOP_XOR = 4'd5;
    localparam logic [3:0] ALUOP_SLL = 4'd6;
    localparam logic [3:0] ALUOP_SRL = 4'd7;
    localparam logic [3:0] ALUOP_SRA = 4'd8;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] F7_ZERO    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_WAIT,
        S_WB
    } state_t;

    state_t state, state_nxt;

    logic [CW-1:0]   wait_cnt;
    logic            wait_last;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic            is_op;
    logic            is_imm;
    logic            dec_legal;
    logic [3:0]      dec_op;
    logic [XLEN-1:0] dec_op2;

    assign opcode   = instr[6:0];
    assign funct3   = instr[14:12];
    assign funct7   = instr[31:25];
    assign rs1_addr = instr[19:15];
    assign rs2_addr = instr[24:20];

    assign instr_ready = (state == S_IDLE);
    assign wait_last   = (wait_cnt == CW'(ALU_LAT - 1));

    // Decode: for OP-IMM the funct7 field is only meaningful on shifts;
    // elsewhere it is part of the immediate.
    always_comb begin
        dec_legal = 1'b0;
        dec_op    = ALUOP_NON;
        dec_op2   = rs2_data;
        is_op     = (opcode == OPC_OP);
        is_imm    = (opcode == OPC_OP_IMM);
        if (is_imm) begin
            dec_op2 = {{(XLEN-12){instr[31]}}, instr[31:20]};
        end
        if (is_op || is_imm) begin
            case (funct3)
                3'b000: begin
                    if (is_imm || funct7 == F7_ZERO) begin
                        dec_legal = 1'b1;
                        dec_op    = ALUOP_ADD;
                    end else if (funct7 == F7_ALT) begin
                        dec_legal = 1'b1;
                        dec_op    = ALUOP_SUB;
                    end
                end
                3'b111: begin
                    if (is_imm || funct7 == F7_ZERO) begin
                        dec_legal = 1'b1;
                        dec_op    = ALUOP_AND;
                    end
                end
                3'b110: begin
                    if (is_imm || funct7 == F7_ZERO) begin
                        dec_legal = 1'b1;
                        dec_op    = ALUOP_OR;
                    end
                end
                3'b100: begin
                    if (is_imm || funct7 == F7_ZERO) begin
                        dec_legal = 1'b1;
                        dec_op    = ALUOP_XOR;
                    end
                end
                3'b001: begin
                    if (is_imm) begin
                        dec_op2 = {{(XLEN-5){1'b0}}, instr[24:20]};
                    end
                    if (funct7 == F7_ZERO) begin
                        dec_legal = 1'b1;
                        dec_op    = ALUOP_SLL;
                    end
                end
                3'b101: begin
                    if (is_imm) begin
                        dec_op2 = {{(XLEN-5){1'b0}}, instr[24:20]};
                    end
                    if (funct7 == F7_ZERO) begin
                        dec_legal = 1'b1;
                        dec_op    = ALUOP_SRL;
                    end else if (funct7 == F7_ALT) begin
                        dec_legal = 1'b1;
                        dec_op    = ALUOP_SRA;
                    end
                end
                default: begin
                    dec_legal = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (instr_valid) begin
                    // Illegal instructions skip the ALU entirely
                    state_nxt = dec_legal ? S_EXEC : S_WB;
                end
            end
            S_EXEC:  state_nxt = S_WAIT;
            S_WAIT:  state_nxt = wait_last ? S_WB : S_WAIT;
            S_WB:    state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs are registered; the pulses are armed on the edge entering WB
    // so they are visible exactly during the WB cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            alu_op      <= ALUOP_NON;
            alu_oprand1 <= '0;
            alu_oprand2 <= '0;
            rd_we       <= 1'b0;
            rd_addr     <= '0;
            rd_wdata    <= '0;
            done        <= 1'b0;
            illegal     <= 1'b0;
            wait_cnt    <= '0;
        end else begin
            rd_we   <= 1'b0;
            done    <= 1'b0;
            illegal <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (instr_valid) begin
                        rd_addr <= instr[11:7];
                        if (dec_legal) begin
                            alu_op      <= dec_op;
                            alu_oprand1 <= rs1_data;
                            alu_oprand2 <= dec_op2;
                        end else begin
                            done    <= 1'b1;
                            illegal <= 1'b1;
                        end
                    end
                end
                S_EXEC: begin
                    // ALU has sampled; drop the op so it holds its result
                    alu_op   <= ALUOP_NON;
                    wait_cnt <= '0;
                end
                S_WAIT: begin
                    if (wait_last) begin
                        rd_wdata <= alu_result;
                        rd_we    <= (rd_addr != 5'd0);
                        done     <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_seq.sv
// tb/tb_alu_issue_seq.sv - directed bench for alu_issue_seq with a registered ALU model

module tb_alu_issue_seq;

    localparam logic [3:0] OP_NON = 4'd0;
    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_AND = 4'd3;
    localparam logic [3:0] OP_OR  = 4'd4;
    localparam logic [3:0] OP_XOR = 4'd5;
    localparam logic [3:0] OP_SLL = 4'd6;
    localparam logic [3:0] OP_SRL = 4'd7;
    localparam logic [3:0] OP_SRA = 4'd8;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] alu_oprand1;
    logic [31:0] alu_oprand2;
    logic [3:0]  alu_op;
    logic [31:0] alu_result;
    logic        rd_we;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata;
    logic        done;
    logic        illegal;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_issue_seq #(.XLEN(32), .ALU_LAT(1)) dut (
        .clk         (clk),
        .reset       (reset),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .rs1_addr    (rs1_addr),
        .rs2_addr    (rs2_addr),
        .rs1_data    (rs1_data),
        .rs2_data    (rs2_data),
        .alu_oprand1 (alu_oprand1),
        .alu_oprand2 (alu_oprand2),
        .alu_op      (alu_op),
        .alu_result  (alu_result),
        .rd_we       (rd_we),
        .rd_addr     (rd_addr),
        .rd_wdata    (rd_wdata),
        .done        (done),
        .illegal     (illegal)
    );

    // Registered ALU responder: computes only when given a real op
    always @(posedge clk) begin
        if (reset) begin
            alu_result <= 32'd0;
        end else begin
            case (alu_op)
                OP_ADD: alu_result <= alu_oprand1 + alu_oprand2;
                OP_SUB: alu_result <= alu_oprand1 - alu_oprand2;
                OP_AND: alu_result <= alu_oprand1 & alu_oprand2;
                OP_OR:  alu_result <= alu_oprand1 | alu_oprand2;
                OP_XOR: alu_result <= alu_oprand1 ^ alu_oprand2;
                OP_SLL: alu_result <= alu_oprand1 << alu_oprand2[4:0];
                OP_SRL: alu_result <= alu_oprand1 >> alu_oprand2[4:0];
                OP_SRA: alu_result <= $signed(alu_oprand1) >>> alu_oprand2[4:0];
                default: alu_result <= alu_result;
            endcase
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [31:0] w, input logic [31:0] a, input logic [31:0] b);
        instr       = w;
        rs1_data    = a;
        rs2_data    = b;
        instr_valid = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1; instr_valid = 1'b0; instr = 32'd0; rs1_data = 32'd0; rs2_data = 32'd0;
        step(); step();
        reset = 1'b0;
        checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", instr_ready); end
        checks++; if (alu_op !== OP_NON) begin errors++; $display("FAIL reset_alu_op got=%0d exp=0", alu_op); end
        checks++; if (alu_oprand1 !== 32'd0 || alu_oprand2 !== 32'd0) begin errors++; $display("FAIL reset_oprand got=%h/%h exp=0/0", alu_oprand1, alu_oprand2); end
        checks++; if ({rd_we, done, illegal} !== 3'b000) begin errors++; $display("FAIL reset_pulses got=%b exp=000", {rd_we, done, illegal}); end
        checks++; if (rd_addr !== 5'd0 || rd_wdata !== 32'd0) begin errors++; $display("FAIL reset_rd got=%0d/%h exp=0/0", rd_addr, rd_wdata); end
    endtask

    task automatic test_add();
        present(32'h002081B3, 32'd5, 32'd7);
        checks++; if (rs1_addr !== 5'd1 || rs2_addr !== 5'd2) begin errors++; $display("FAIL add_rs_addr got=%0d/%0d exp=1/2", rs1_addr, rs2_addr); end
        step(); instr_valid = 1'b0;
        checks++; if (alu_op !== OP_ADD) begin errors++; $display("FAIL add_exec_op got=%0d exp=%0d", alu_op, OP_ADD); end
        checks++; if (alu_oprand1 !== 32'd5 || alu_oprand2 !== 32'd7) begin errors++; $display("FAIL add_exec_oprand got=%h/%h exp=5/7", alu_oprand1, alu_oprand2); end
        checks++; if (instr_ready !== 1'b0) begin errors++; $display("FAIL add_exec_ready got=%b exp=0", instr_ready); end
        step();
        checks++; if (alu_op !== OP_NON) begin errors++; $display("FAIL add_wait_op got=%0d exp=0", alu_op); end
        checks++; if (rd_we !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL add_wait_pulse got=%b%b exp=00", rd_we, done); end
        step();
        checks++; if (rd_we !== 1'b1 || done !== 1'b1 || illegal !== 1'b0) begin errors++; $display("FAIL add_wb_pulse got=%b%b%b exp=110", rd_we, done, illegal); end
        checks++; if (rd_addr !== 5'd3 || rd_wdata !== 32'd12) begin errors++; $display("FAIL add_wb_data got=%0d/%h exp=3/0000000c", rd_addr, rd_wdata); end
        step();
        checks++; if (instr_ready !== 1'b1 || rd_we !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL add_idle got=%b%b%b exp=100", instr_ready, rd_we, done); end
    endtask

    task automatic test_alu_ops();
        logic [31:0] w [4]   = '{32'h402082B3, 32'h4040D213, 32'hFFF08313, 32'h0020C3B3};
        logic [31:0] a [4]   = '{32'd3, 32'h80000000, 32'd10, 32'hF0F0F0F0};
        logic [31:0] b [4]   = '{32'd5, 32'd0, 32'd0, 32'h0FF00FF0};
        logic [3:0]  op [4]  = '{OP_SUB, OP_SRA, OP_ADD, OP_XOR};
        logic [31:0] o2 [4]  = '{32'd5, 32'd4, 32'hFFFFFFFF, 32'h0FF00FF0};
        logic [4:0]  rd [4]  = '{5'd5, 5'd4, 5'd6, 5'd7};
        logic [31:0] res [4] = '{32'hFFFFFFFE, 32'hF8000000, 32'd9, 32'hFF00FF00};
        for (int i = 0; i < 4; i++) begin
            present(w[i], a[i], b[i]);
            step(); instr_valid = 1'b0;
            checks++; if (alu_op !== op[i] || alu_oprand2 !== o2[i]) begin errors++; $display("FAIL ops_exec[%0d] got op=%0d op2=%h exp op=%0d op2=%h", i, alu_op, alu_oprand2, op[i], o2[i]); end
            step(); step();
            checks++; if (rd_we !== 1'b1 || rd_addr !== rd[i] || rd_wdata !== res[i]) begin errors++; $display("FAIL ops_wb[%0d] got we=%b rd=%0d data=%h exp we=1 rd=%0d data=%h", i, rd_we, rd_addr, rd_wdata, rd[i], res[i]); end
            step();
        end
    endtask

    task automatic test_rd_x0();
        present(32'h00108013, 32'd41, 32'd0);
        step(); instr_valid = 1'b0;
        step(); step();
        checks++; if (done !== 1'b1 || rd_we !== 1'b0 || illegal !== 1'b0) begin errors++; $display("FAIL x0_wb got done=%b we=%b ill=%b exp 1/0/0", done, rd_we, illegal); end
        step();
    endtask

    task automatic test_illegal();
        logic [31:0] w [2] = '{32'h003120B3, 32'h022081B3};
        for (int i = 0; i < 2; i++) begin
            present(w[i], 32'd1, 32'd2);
            step(); instr_valid = 1'b0;
            checks++; if (done !== 1'b1 || illegal !== 1'b1 || rd_we !== 1'b0) begin errors++; $display("FAIL illegal[%0d] got done=%b ill=%b we=%b exp 1/1/0", i, done, illegal, rd_we); end
            checks++; if (alu_op !== OP_NON) begin errors++; $display("FAIL illegal_op[%0d] got=%0d exp=0", i, alu_op); end
            step();
            checks++; if (instr_ready !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL illegal_idle[%0d] got ready=%b done=%b exp 1/0", i, instr_ready, done); end
        end
    endtask

    task automatic test_back_to_back();
        int low_cycles = 0;
        present(32'h002081B3, 32'd1, 32'd2);
        step();
        // Second word presented early; it must be ignored until IDLE
        present(32'h402082B3, 32'd100, 32'd1);
        for (int c = 0; c < 3; c++) begin
            if (instr_ready === 1'b0) low_cycles++;
            if (c < 2) step();
        end
        checks++; if (low_cycles != 3) begin errors++; $display("FAIL b2b_ready_low got=%0d exp=3", low_cycles); end
        checks++; if (done !== 1'b1 || rd_addr !== 5'd3 || rd_wdata !== 32'd3) begin errors++; $display("FAIL b2b_first got done=%b rd=%0d data=%h exp 1/3/00000003", done, rd_addr, rd_wdata); end
        step();
        checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL b2b_accept_ready got=%b exp=1", instr_ready); end
        rs1_data = 32'd10; rs2_data = 32'd4;
        step(); instr_valid = 1'b0;
        checks++; if (alu_op !== OP_SUB || alu_oprand1 !== 32'd10) begin errors++; $display("FAIL b2b_second_exec got op=%0d op1=%h exp %0d/0000000a", alu_op, alu_oprand1, OP_SUB); end
        step(); step();
        checks++; if (rd_we !== 1'b1 || rd_addr !== 5'd5 || rd_wdata !== 32'd6) begin errors++; $display("FAIL b2b_second_wb got we=%b rd=%0d data=%h exp 1/5/00000006", rd_we, rd_addr, rd_wdata); end
        step();
    endtask

    task automatic test_reset_mid();
        present(32'h002081B3, 32'd20, 32'd22);
        step(); instr_valid = 1'b0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++; if (instr_ready !== 1'b1 || rd_we !== 1'b0 || done !== 1'b0 || alu_op !== OP_NON) begin errors++; $display("FAIL rstmid_idle got ready=%b we=%b done=%b op=%0d exp 1/0/0/0", instr_ready, rd_we, done, alu_op); end
        step();
        checks++; if (rd_we !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rstmid_nopulse got we=%b done=%b exp 0/0", rd_we, done); end
        present(32'h0020E3B3, 32'hA0, 32'h05);
        step(); instr_valid = 1'b0;
        checks++; if (alu_op !== OP_OR) begin errors++; $display("FAIL rstmid_next_op got=%0d exp=%0d", alu_op, OP_OR); end
        step(); step();
        checks++; if (rd_we !== 1'b1 || rd_addr !== 5'd7 || rd_wdata !== 32'hA5) begin errors++; $display("FAIL rstmid_next_wb got we=%b rd=%0d data=%h exp 1/7/000000a5", rd_we, rd_addr, rd_wdata); end
        step();
    endtask

    initial begin
        test_reset();
        test_add();
        test_alu_ops();
        test_rd_x0();
        test_illegal();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
